// File: rtl/garnet_shell_top.sv
// garnet_shell_top: CGRA shell with AXI4-Lite CSRs, proc-port global-buffer SRAM, run-length kernel engine, gated run clock.
// Ports: clk_in/reset_in (sync, active-high); interrupt = DONE & IER; cgra_running_clk_out = clk_in gated by running;
//        proc_packet_* = byte-strobed SRAM write / registered read; axi4_slave_* = AXI4-Lite CSR slave; jtag_* stubbed.
// Optional: define GARNET_SHELL_AXIL_SLVERR_EN to answer unmapped/illegal accesses with SLVERR.
module garnet_shell_top #(
  parameter int AXI_ADDR_WIDTH = 13,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int GLB_ADDR_WIDTH = 22,
  parameter int GLB_DATA_WIDTH = 64,
  parameter int GLB_DEPTH = 256,
  parameter logic [AXI_DATA_WIDTH-1:0] ID_VALUE = 32'h6761_726E
) (
  input  logic                        clk_in,
  input  logic                        reset_in,
  output logic                        interrupt,
  output logic                        cgra_running_clk_out,
  input  logic                        proc_packet_wr_en,
  input  logic [GLB_DATA_WIDTH/8-1:0] proc_packet_wr_strb,
  input  logic [GLB_ADDR_WIDTH-1:0]   proc_packet_wr_addr,
  input  logic [GLB_DATA_WIDTH-1:0]   proc_packet_wr_data,
  input  logic                        proc_packet_rd_en,
  input  logic [GLB_ADDR_WIDTH-1:0]   proc_packet_rd_addr,
  output logic [GLB_DATA_WIDTH-1:0]   proc_packet_rd_data,
  output logic                        proc_packet_rd_data_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi4_slave_awaddr,
  input  logic                        axi4_slave_awvalid,
  output logic                        axi4_slave_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi4_slave_wdata,
  input  logic                        axi4_slave_wvalid,
  output logic                        axi4_slave_wready,
  output logic [1:0]                  axi4_slave_bresp,
  output logic                        axi4_slave_bvalid,
  input  logic                        axi4_slave_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi4_slave_araddr,
  input  logic                        axi4_slave_arvalid,
  output logic                        axi4_slave_arready,
  output logic [AXI_DATA_WIDTH-1:0]   axi4_slave_rdata,
  output logic [1:0]                  axi4_slave_rresp,
  output logic                        axi4_slave_rvalid,
  input  logic                        axi4_slave_rready,
  input  logic                        jtag_tck,
  input  logic                        jtag_tdi,
  input  logic                        jtag_tms,
  input  logic                        jtag_trst_n,
  output logic                        jtag_tdo
);
  localparam int DW = AXI_DATA_WIDTH;
  localparam int SW = GLB_DATA_WIDTH / 8;
  localparam int IW = $clog2(GLB_DEPTH);
  logic live, aw_full, w_full, running, done, ier, en_lat;
  logic wr, wr_ok, w_map, r_map, w_err, r_err, start, clr, fin, unused_ok;
  logic [2:0] w_idx, r_idx;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [DW-1:0] w_data, cycles, cnt, scratch, rd_mux;
  logic [GLB_DATA_WIDTH-1:0] mem [GLB_DEPTH];
  assign w_idx = aw_addr[4:2];
  assign r_idx = axi4_slave_araddr[4:2];
  assign w_map = (aw_addr[AXI_ADDR_WIDTH-1:5] == '0) && (w_idx != 3'd7);
  assign r_map = (axi4_slave_araddr[AXI_ADDR_WIDTH-1:5] == '0) && (r_idx != 3'd7);
`ifdef GARNET_SHELL_AXIL_SLVERR_EN
  assign w_err = !w_map || w_idx == 3'd0 || w_idx == 3'd5 || (w_idx == 3'd2 && w_data[0]);
  assign r_err = !r_map;
`else
  assign w_err = 1'b0;
  assign r_err = 1'b0;
`endif
  // The register write fires once: both slots full and the response not yet raised.
  assign wr = aw_full && w_full && !axi4_slave_bvalid;
  assign wr_ok = wr && w_map && !w_err;
  assign start = wr_ok && w_idx == 3'd1 && w_data[0];
  assign clr = wr_ok && w_idx == 3'd2 && w_data[1];
  assign fin = (running && cnt == DW'(1)) || (start && !running && cycles == '0);
  assign axi4_slave_awready = live && !aw_full && !axi4_slave_bvalid;
  assign axi4_slave_wready = live && !w_full && !axi4_slave_bvalid;
  assign axi4_slave_arready = live && !axi4_slave_rvalid;
  assign interrupt = done && ier;
  assign jtag_tdo = 1'b0;
  always_comb begin
    rd_mux = '0;
    case (r_idx)
      3'd0: rd_mux = ID_VALUE;
      3'd2: rd_mux = {{(DW-2){1'b0}}, done, running};
      3'd3: rd_mux = {{(DW-1){1'b0}}, ier};
      3'd4: rd_mux = cycles;
      3'd5: rd_mux = cnt;
      3'd6: rd_mux = scratch;
      default: ;
    endcase
    if (!r_map) rd_mux = '0;
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      live <= 1'b0;
      aw_full <= 1'b0;
      w_full <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      axi4_slave_bvalid <= 1'b0;
      axi4_slave_bresp <= 2'b00;
      axi4_slave_rvalid <= 1'b0;
      axi4_slave_rresp <= 2'b00;
      axi4_slave_rdata <= '0;
      running <= 1'b0;
      done <= 1'b0;
      ier <= 1'b0;
      cycles <= '0;
      cnt <= '0;
      scratch <= '0;
      proc_packet_rd_data <= '0;
      proc_packet_rd_data_valid <= 1'b0;
    end else begin
      live <= 1'b1;
      if (axi4_slave_awvalid && axi4_slave_awready) begin
        aw_full <= 1'b1;
        aw_addr <= axi4_slave_awaddr;
      end
      if (axi4_slave_wvalid && axi4_slave_wready) begin
        w_full <= 1'b1;
        w_data <= axi4_slave_wdata;
      end
      if (wr) begin
        axi4_slave_bvalid <= 1'b1;
        axi4_slave_bresp <= w_err ? 2'b10 : 2'b00;
      end else if (axi4_slave_bvalid && axi4_slave_bready) begin
        axi4_slave_bvalid <= 1'b0;
        aw_full <= 1'b0;
        w_full <= 1'b0;
      end
      if (axi4_slave_arvalid && axi4_slave_arready) begin
        axi4_slave_rvalid <= 1'b1;
        axi4_slave_rdata <= rd_mux;
        axi4_slave_rresp <= r_err ? 2'b10 : 2'b00;
      end else if (axi4_slave_rvalid && axi4_slave_rready) begin
        axi4_slave_rvalid <= 1'b0;
      end
      if (wr_ok && w_idx == 3'd3) ier <= w_data[0];
      if (wr_ok && w_idx == 3'd4) cycles <= w_data;
      if (wr_ok && w_idx == 3'd6) scratch <= w_data;
      if (running) begin
        cnt <= cnt - DW'(1);
        if (cnt == DW'(1)) running <= 1'b0;
      end else if (start && cycles != '0) begin
        running <= 1'b1;
        cnt <= cycles;
      end
      done <= fin || (done && !clr);
      proc_packet_rd_data_valid <= proc_packet_rd_en;
      if (proc_packet_rd_en) proc_packet_rd_data <= mem[proc_packet_rd_addr[3 +: IW]];
    end
  end
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < SW; i++)
      if (proc_packet_wr_en && proc_packet_wr_strb[i])
        mem[proc_packet_wr_addr[3 +: IW]][i*8 +: 8] <= proc_packet_wr_data[i*8 +: 8];
  end
  // Enable is captured only while clk_in is low so the gated clock never chops a high phase.
  always_latch begin
    if (!clk_in) en_lat <= running;
  end
  assign cgra_running_clk_out = clk_in & en_lat;
  assign unused_ok = ^{jtag_tck, jtag_tdi, jtag_tms, jtag_trst_n, aw_addr[1:0], axi4_slave_araddr[1:0],
                       proc_packet_wr_addr[2:0], proc_packet_wr_addr[GLB_ADDR_WIDTH-1:3+IW],
                       proc_packet_rd_addr[2:0], proc_packet_rd_addr[GLB_ADDR_WIDTH-1:3+IW]};
endmodule

// File: tb/tb_garnet_shell_top.sv
// tb_garnet_shell_top: scoreboard bench for garnet_shell_top.
module tb_garnet_shell_top;
`ifdef GARNET_SHELL_AXIL_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif
  localparam logic [31:0] ID = 32'h6761_726E;
  logic clk_in = 0, reset_in;
  logic interrupt, cgra_running_clk_out;
  logic proc_packet_wr_en, proc_packet_rd_en, proc_packet_rd_data_valid;
  logic [7:0] proc_packet_wr_strb;
  logic [21:0] proc_packet_wr_addr, proc_packet_rd_addr;
  logic [63:0] proc_packet_wr_data, proc_packet_rd_data;
  logic [12:0] axi4_slave_awaddr, axi4_slave_araddr;
  logic axi4_slave_awvalid, axi4_slave_awready, axi4_slave_wvalid, axi4_slave_wready;
  logic axi4_slave_bvalid, axi4_slave_bready, axi4_slave_arvalid, axi4_slave_arready;
  logic axi4_slave_rvalid, axi4_slave_rready;
  logic [31:0] axi4_slave_wdata, axi4_slave_rdata;
  logic [1:0] axi4_slave_bresp, axi4_slave_rresp;
  logic jtag_tdo;
  int errors = 0, checks = 0, b_count = 0, r_count = 0, p_count = 0, g_count = 0;
  int nw = 0, nr = 0, np = 0;
  logic [1:0] bq[$];
  logic [33:0] rq[$];
  logic [63:0] pq[$];

  garnet_shell_top dut (
    .clk_in(clk_in), .reset_in(reset_in), .interrupt(interrupt), .cgra_running_clk_out(cgra_running_clk_out),
    .proc_packet_wr_en(proc_packet_wr_en), .proc_packet_wr_strb(proc_packet_wr_strb),
    .proc_packet_wr_addr(proc_packet_wr_addr), .proc_packet_wr_data(proc_packet_wr_data),
    .proc_packet_rd_en(proc_packet_rd_en), .proc_packet_rd_addr(proc_packet_rd_addr),
    .proc_packet_rd_data(proc_packet_rd_data), .proc_packet_rd_data_valid(proc_packet_rd_data_valid),
    .axi4_slave_awaddr(axi4_slave_awaddr), .axi4_slave_awvalid(axi4_slave_awvalid), .axi4_slave_awready(axi4_slave_awready),
    .axi4_slave_wdata(axi4_slave_wdata), .axi4_slave_wvalid(axi4_slave_wvalid), .axi4_slave_wready(axi4_slave_wready),
    .axi4_slave_bresp(axi4_slave_bresp), .axi4_slave_bvalid(axi4_slave_bvalid), .axi4_slave_bready(axi4_slave_bready),
    .axi4_slave_araddr(axi4_slave_araddr), .axi4_slave_arvalid(axi4_slave_arvalid), .axi4_slave_arready(axi4_slave_arready),
    .axi4_slave_rdata(axi4_slave_rdata), .axi4_slave_rresp(axi4_slave_rresp), .axi4_slave_rvalid(axi4_slave_rvalid),
    .axi4_slave_rready(axi4_slave_rready),
    .jtag_tck(1'b0), .jtag_tdi(1'b0), .jtag_tms(1'b0), .jtag_trst_n(1'b1), .jtag_tdo(jtag_tdo)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge cgra_running_clk_out) g_count++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no response expected one", nm);
  endtask

  always @(negedge clk_in) begin
    if (axi4_slave_bvalid && axi4_slave_bready) begin
      b_count++;
      if (bq.size() == 0) chk("bresp_unexpected", 1, 0);
      else chk("bresp", axi4_slave_bresp, bq.pop_front());
    end
    if (axi4_slave_rvalid && axi4_slave_rready) begin
      r_count++;
      if (rq.size() == 0) chk("rdata_unexpected", 1, 0);
      else chk("rresp_rdata", {axi4_slave_rresp, axi4_slave_rdata}, rq.pop_front());
    end
    if (proc_packet_rd_data_valid) begin
      p_count++;
      if (pq.size() == 0) chk("rd_data_unexpected", 1, 0);
      else chk("rd_data", proc_packet_rd_data, pq.pop_front());
    end
  end

  task automatic wait_bresp(input int nb);
    int n = 0;
    while (b_count == nb && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    if (b_count == nb) timeout("bvalid");
  endtask

  task automatic axi_write(input logic [12:0] a, input logic [31:0] d, input int lead, input logic [1:0] er, input bit wait_b);
    int n = 0, nb;
    bit aw_hs, w_hs, aw_sent;
    @(posedge clk_in); #1;
    nb = b_count;
    bq.push_back(er);
    nw++;
    axi4_slave_awaddr = a;
    axi4_slave_wdata = d;
    axi4_slave_wvalid = 1;
    axi4_slave_awvalid = (lead == 0);
    aw_sent = (lead == 0);
    while (axi4_slave_awvalid || axi4_slave_wvalid || !aw_sent) begin
      @(negedge clk_in);
      aw_hs = axi4_slave_awvalid && axi4_slave_awready;
      w_hs = axi4_slave_wvalid && axi4_slave_wready;
      @(posedge clk_in); #1;
      if (aw_hs) axi4_slave_awvalid = 0;
      if (w_hs) axi4_slave_wvalid = 0;
      n++;
      if (!aw_sent && n >= lead) begin
        axi4_slave_awvalid = 1;
        aw_sent = 1;
      end
      if (n > 40) begin
        timeout("aw_w_handshake");
        axi4_slave_awvalid = 0;
        axi4_slave_wvalid = 0;
        aw_sent = 1;
      end
    end
    if (wait_b) wait_bresp(nb);
  endtask

  task automatic axi_read(input logic [12:0] a, input logic [31:0] e, input logic [1:0] er);
    int n = 0, nr0;
    bit hs;
    @(posedge clk_in); #1;
    nr0 = r_count;
    rq.push_back({er, e});
    nr++;
    axi4_slave_araddr = a;
    axi4_slave_arvalid = 1;
    while (axi4_slave_arvalid) begin
      @(negedge clk_in);
      hs = axi4_slave_arready;
      @(posedge clk_in); #1;
      if (hs) axi4_slave_arvalid = 0;
      n++;
      if (n > 40) begin
        timeout("ar_handshake");
        axi4_slave_arvalid = 0;
      end
    end
    n = 0;
    while (r_count == nr0 && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    if (r_count == nr0) timeout("rvalid");
  endtask

  task automatic proc_write(input logic [21:0] a, input logic [63:0] d, input logic [7:0] s);
    @(posedge clk_in); #1;
    proc_packet_wr_en = 1;
    proc_packet_wr_addr = a;
    proc_packet_wr_data = d;
    proc_packet_wr_strb = s;
    @(posedge clk_in); #1;
    proc_packet_wr_en = 0;
  endtask

  task automatic proc_read(input logic [21:0] a, input logic [63:0] e);
    @(posedge clk_in); #1;
    pq.push_back(e);
    np++;
    proc_packet_rd_en = 1;
    proc_packet_rd_addr = a;
    @(posedge clk_in); #1;
    proc_packet_rd_en = 0;
    @(negedge clk_in);
    chk("rd_valid_pulse", proc_packet_rd_data_valid, 1);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    chk("rd_valid_drop", proc_packet_rd_data_valid, 0);
    chk("rd_data_hold", proc_packet_rd_data, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int g0, nb, n;
    reset_in = 1;
    proc_packet_wr_en = 0; proc_packet_rd_en = 0; proc_packet_wr_strb = 0;
    proc_packet_wr_addr = 0; proc_packet_rd_addr = 0; proc_packet_wr_data = 0;
    axi4_slave_awaddr = 0; axi4_slave_awvalid = 0; axi4_slave_wdata = 0; axi4_slave_wvalid = 0;
    axi4_slave_bready = 1; axi4_slave_araddr = 0; axi4_slave_arvalid = 0; axi4_slave_rready = 1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_interrupt", interrupt, 0);
    chk("rst_bvalid", axi4_slave_bvalid, 0);
    chk("rst_rvalid", axi4_slave_rvalid, 0);
    chk("rst_readies", {axi4_slave_awready, axi4_slave_wready, axi4_slave_arready}, 0);
    chk("rst_resp", {axi4_slave_bresp, axi4_slave_rresp}, 0);
    chk("rst_rdata", axi4_slave_rdata, 0);
    chk("rst_rd_valid", proc_packet_rd_data_valid, 0);
    chk("rst_rd_data", proc_packet_rd_data, 0);
    chk("rst_tdo", jtag_tdo, 0);
    @(posedge clk_in); #1;
    reset_in = 0;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("post_rst_readies", {axi4_slave_awready, axi4_slave_wready, axi4_slave_arready}, 3'b111);
    axi_read(13'h00, ID, 2'b00);
    // W leads AW by two cycles, response stalled by bready low
    axi4_slave_bready = 0;
    nb = b_count;
    axi_write(13'h18, 32'hDEAD_BEEF, 2, 2'b00, 0);
    n = 0;
    while (!axi4_slave_bvalid && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    if (!axi4_slave_bvalid) timeout("bvalid_rise");
    repeat (5) begin
      @(negedge clk_in);
      chk("bvalid_hold", axi4_slave_bvalid, 1);
    end
    axi4_slave_bready = 1;
    wait_bresp(nb);
    @(negedge clk_in);
    chk("bvalid_single_pulse", b_count, nb + 1);
    axi_read(13'h18, 32'hDEAD_BEEF, 2'b00);
    axi_write(13'h18, 32'h1234_5678, 0, 2'b00, 1);
    axi_read(13'h1B, 32'h1234_5678, 2'b00);
    // Run five cycles with interrupt enabled
    axi_write(13'h10, 32'd5, 0, 2'b00, 1);
    axi_write(13'h0C, 32'd1, 0, 2'b00, 1);
    g0 = g_count;
    axi_write(13'h04, 32'd1, 0, 2'b00, 1);
    repeat (15) @(negedge clk_in);
    chk("run5_gated_pulses", g_count - g0, 5);
    chk("run5_interrupt", interrupt, 1);
    axi_read(13'h08, 32'h2, 2'b00);
    axi_read(13'h14, 32'h0, 2'b00);
    axi_read(13'h04, 32'h0, 2'b00);
    axi_read(13'h10, 32'd5, 2'b00);
    axi_write(13'h08, 32'h2, 0, 2'b00, 1);
    chk("w1c_interrupt", interrupt, 0);
    axi_read(13'h08, 32'h0, 2'b00);
    // Second START during a run is ignored
    axi_write(13'h10, 32'd8, 0, 2'b00, 1);
    g0 = g_count;
    axi_write(13'h04, 32'd1, 0, 2'b00, 1);
    axi_write(13'h04, 32'd1, 0, 2'b00, 1);
    repeat (20) @(negedge clk_in);
    chk("run8_ignore_restart", g_count - g0, 8);
    axi_write(13'h08, 32'h2, 0, 2'b00, 1);
    // START with CYCLES=0 sets DONE without running
    axi_write(13'h10, 32'd0, 0, 2'b00, 1);
    g0 = g_count;
    axi_write(13'h04, 32'd1, 0, 2'b00, 1);
    chk("zero_run_done", interrupt, 1);
    repeat (5) @(negedge clk_in);
    chk("zero_run_no_clock", g_count - g0, 0);
    axi_read(13'h08, 32'h2, 2'b00);
    axi_write(13'h08, 32'h2, 0, 2'b00, 1);
    // Unmapped and read-only targets
    axi_write(13'h1C, 32'h1234, 0, ERR, 1);
    axi_read(13'h1C, 32'h0, ERR);
    axi_read(13'h100, 32'h0, ERR);
    axi_write(13'h00, 32'h1, 0, ERR, 1);
    axi_read(13'h00, ID, 2'b00);
    // SRAM byte strobes, aliasing, read-during-write
    proc_write(22'h10, 64'h0123_4567_89AB_CDEF, 8'hFF);
    proc_write(22'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
    proc_read(22'h10, 64'h0123_4567_89AB_CDFF);
    proc_write(22'h800, 64'hA5A5_0000_1111_2222, 8'hFF);
    proc_read(22'h0, 64'hA5A5_0000_1111_2222);
    proc_read(22'h3FF807, 64'hA5A5_0000_1111_2222);
    proc_write(22'h18, 64'h0, 8'hFF);
    proc_write(22'h18, 64'h1122_3344_5566_7788, 8'h3C);
    proc_read(22'h18, 64'h0000_3344_5566_0000);
    @(posedge clk_in); #1;
    pq.push_back(64'hA5A5_0000_1111_2222);
    np++;
    proc_packet_wr_en = 1; proc_packet_wr_addr = 22'h0; proc_packet_wr_data = 64'hCAFE_F00D_0BAD_BEEF; proc_packet_wr_strb = 8'hFF;
    proc_packet_rd_en = 1; proc_packet_rd_addr = 22'h0;
    @(posedge clk_in); #1;
    proc_packet_wr_en = 0; proc_packet_rd_en = 0;
    proc_read(22'h0, 64'hCAFE_F00D_0BAD_BEEF);
    // Reset during a run aborts it, keeps SRAM
    axi_write(13'h10, 32'd50, 0, 2'b00, 1);
    axi_write(13'h04, 32'd1, 0, 2'b00, 1);
    repeat (3) @(negedge clk_in);
    @(posedge clk_in); #1;
    reset_in = 1;
    repeat (2) @(posedge clk_in);
    #1 reset_in = 0;
    g0 = g_count;
    repeat (10) @(negedge clk_in);
    chk("reset_stops_run", g_count - g0, 0);
    chk("reset_interrupt", interrupt, 0);
    axi_read(13'h08, 32'h0, 2'b00);
    axi_read(13'h10, 32'h0, 2'b00);
    axi_read(13'h18, 32'h0, 2'b00);
    proc_read(22'h10, 64'h0123_4567_89AB_CDFF);
    repeat (3) @(negedge clk_in);
    chk("b_count", b_count, nw);
    chk("r_count", r_count, nr);
    chk("p_count", p_count, np);
    chk("queues_empty", bq.size() + rq.size() + pq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/garnet_shell_top.md
Name: garnet_shell_top

Overview:
- Simplified CGRA top-level shell for system-level testbenches.
- Provides an AXI4-Lite control/status register slave, a processor packet port onto a byte-strobed global-buffer SRAM, a run-length "kernel" engine with done interrupt, a gated running clock, and stubbed JTAG pins.
- Sits at the chip top, between the host testbench and the (abstracted) CGRA fabric.

Parameters:
- AXI_ADDR_WIDTH, 13, AXI-Lite address width.
- AXI_DATA_WIDTH, 32, AXI-Lite data width.
- GLB_ADDR_WIDTH, 22, proc byte-address width.
- GLB_DATA_WIDTH, 64, proc data width; strobe width is GLB_DATA_WIDTH/8.
- GLB_DEPTH, 256, SRAM words (power of two).
- ID_VALUE, 32'h6761_726E, value of ID register.

Ports:
- clk_in  in  1  sole clock, rising edge.
- reset_in  in  1  synchronous active-high reset.
- interrupt  out  1  done interrupt, level.
- cgra_running_clk_out  out  1  clk_in gated by running.
- proc_packet_wr_en  in  1  SRAM write request.
- proc_packet_wr_strb  in  8  byte enables.
- proc_packet_wr_addr  in  22  byte address.
- proc_packet_wr_data  in  64  write data.
- proc_packet_rd_en  in  1  SRAM read request.
- proc_packet_rd_addr  in  22  byte address.
- proc_packet_rd_data  out  64  read data.
- proc_packet_rd_data_valid  out  1  read data valid pulse.
- axi4_slave_awaddr/awvalid  in  13/1; axi4_slave_awready  out 1.
- axi4_slave_wdata/wvalid  in  32/1; axi4_slave_wready  out 1.
- axi4_slave_bresp  out 2; axi4_slave_bvalid  out 1; axi4_slave_bready  in 1.
- axi4_slave_araddr/arvalid  in  13/1; axi4_slave_arready  out 1.
- axi4_slave_rdata  out 32; axi4_slave_rresp  out 2; axi4_slave_rvalid  out 1; axi4_slave_rready  in 1.
- jtag_tck, jtag_tdi, jtag_tms, jtag_trst_n  in  1  ignored.
- jtag_tdo  out  1  tied 0.

Behaviour:
- Reset values: all readies 0, then 1 on the first cycle after reset deasserts. bvalid, rvalid, bresp, rresp, rdata, interrupt, rd_data_valid, rd_data, running, done, IER, CYCLES, CNT, SCRATCH all 0. SRAM contents are not reset.
- AW/W channels are independent:
  - awready=1 while no address is captured and bvalid=0; the address is captured on awvalid&awready. W channel works the same way.
  - Once both are held, the register write happens and bvalid rises next cycle.
  - bvalid holds until bready; then both capture slots clear.
- Read channel: arready=!rvalid. On arvalid&arready, rdata/rresp are registered and rvalid=1 next cycle, held until rready.
- Register map (byte offsets; addr[1:0] ignored):
  - 0x00 ID RO.
  - 0x04 CTRL: bit0 START, write-1 pulse, reads 0.
  - 0x08 STATUS: bit0 RUNNING RO; bit1 DONE, write-1-to-clear.
  - 0x0C IER: bit0 RW.
  - 0x10 CYCLES RW.
  - 0x14 CNT RO.
  - 0x18 SCRATCH RW.
  - Unmapped: reads 0, writes dropped, resp OKAY (2'b00).
- Run engine:
  - START while !running and CYCLES!=0: running=1, CNT=CYCLES next cycle.
  - Each running cycle CNT decrements. When CNT==1: CNT→0, running→0, DONE→1. RUNNING is therefore high for exactly CYCLES cycles.
  - START with CYCLES=0: DONE=1 next cycle, running stays 0.
  - START while running is ignored.
  - If DONE-set and W1C clear occur in the same cycle, set wins.
- interrupt = DONE & IER[0].
- cgra_running_clk_out: latch-based clock gate; the enable latch is transparent while clk_in is low; output = clk_in & latched running. No glitches.
- SRAM:
  - Word index = addr[3 +: log2(GLB_DEPTH)]; upper bits ignored (aliasing/wrap).
  - Write: bytes with strb=1 are updated at the edge.
  - Read: rd_data registered, rd_data_valid=1 for exactly one cycle after rd_en; rd_data holds its value otherwise.
  - Same-cycle read and write to the same word returns old data.
- Reset mid-transaction: aborts any pending AXI response and the run; SRAM is kept.

Optional Feature:
- GARNET_SHELL_AXIL_SLVERR_EN.
  - Defined: accesses to unmapped offsets (≥0x1C) return bresp/rresp=2'b10 (SLVERR); writes to ID, CNT and STATUS bit0 also return SLVERR with no effect.
  - Undefined: all responses are OKAY.

Test Plan:
- Reset 3 cycles high → all outputs 0; read 0x00 → rdata 0x6761726E, rresp 0.
- AXI write SCRATCH=0xDEADBEEF, with W sent 2 cycles before AW → one bvalid pulse per write; readback 0xDEADBEEF; bready held low 5 cycles → bvalid stays high.
- CYCLES=5, IER=1, START → RUNNING high exactly 5 cycles; cgra_running_clk_out toggles 5 times; DONE=1 and interrupt=1; write STATUS=0x2 → interrupt 0.
- Proc write addr 0x10, data 0x0123456789ABCDEF, strb 0xFF; then write 0xFFFF…, strb 0x01 → read returns 0x01234567_89ABCDFF one cycle later with a valid pulse.
- Proc write at addr 0x800 (GLB_DEPTH=256) → read at 0x0 returns the same data (wrap).
- START with CYCLES=0 → DONE next cycle, RUNNING never 1.
